ecc_apb_driver: RTL and testbench

ECC_APB_DRIVER -- requirements
Module: ecc_apb_driver

---
 rtl/ecc_apb_driver.sv | 170 +++++++++++++++++
 tb/tb_ecc_apb_driver.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_apb_driver.sv
// ecc_apb_driver
//   Takes one ECC job at a time and programs the ECC block over APB. Each job
//   becomes four back-to-back writes (DATA_IN @0x04, CODEWORD_WIDTH @0x08,
//   NOISE @0x0C, CTRL @0x00). The driver then waits a bounded time for
//   operation_done and returns one result beat.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   job_valid/job_ready job handshake. A job transfers in any cycle where both
//                       are high. job_valid may be held and job fields may
//                       change freely while job_ready is low. job_ready is
//                       high only while the driver is idle.
//   job_ctrl/width/data/noise  register values for the job
//   PADDR..PWRITE       APB initiator outputs (write-only, no wait states)
//   PRDATA              APB read data (no read transfers are issued)
//   operation_done, data_out, num_of_errors  ECC block status
//   res_valid           one-cycle strobe. res_data/res_errors/res_err hold
//                       their values until the next strobe.
//   dbg_state           current FSM state for observation
module ecc_apb_driver #(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int DATA_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [1:0]                 job_ctrl,
  input  logic [1:0]                 job_width,
  input  logic [DATA_WIDTH-1:0]      job_data,
  input  logic [DATA_WIDTH-1:0]      job_noise,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic [AMBA_WORD-1:0]       PWDATA,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  input  logic [AMBA_WORD-1:0]       PRDATA,
  input  logic                       operation_done,
  input  logic [DATA_WIDTH-1:0]      data_out,
  input  logic [1:0]                 num_of_errors,
  output logic                       res_valid,
  output logic [DATA_WIDTH-1:0]      res_data,
  output logic [1:0]                 res_errors,
  output logic                       res_err,
  output logic [2:0]                 dbg_state
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETUP     = 3'd1,
    ACCESS    = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } state_t;

  state_t                  state, next_state;
  logic [1:0]              wr_idx;
  logic [CW-1:0]           cnt;
  logic [1:0]              lat_ctrl, lat_width;
  logic [DATA_WIDTH-1:0]   lat_data, lat_noise;
  logic                    lat_bad;
  logic                    accept;
  logic                    timeout;
  logic                    prdata_unused;

  // No read transfers are ever issued, so read data is deliberately ignored.
  assign prdata_unused = ^PRDATA;

  assign accept    = (state == IDLE) && job_valid && job_ready;
  assign timeout   = (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      job_ready  <= 1'b0;
      wr_idx     <= 2'd0;
      cnt        <= '0;
      lat_ctrl   <= 2'd0;
      lat_width  <= 2'd0;
      lat_data   <= '0;
      lat_noise  <= '0;
      lat_bad    <= 1'b0;
      res_data   <= '0;
      res_errors <= 2'd0;
      res_err    <= 1'b0;
    end else begin
      state <= next_state;
      // job_ready is a flop so it stays low throughout reset and rises on
      // the first edge after release. It is also high the cycle after RESP.
      job_ready <= (next_state == IDLE);

      if (accept) begin
        lat_ctrl  <= job_ctrl;
        lat_width <= job_width;
        lat_data  <= job_data;
        lat_noise <= job_noise;
        // A reserved code skips the APB writes and goes straight to an
        // error result through WAIT_DONE.
        lat_bad   <= (job_ctrl == 2'b11) || (job_width == 2'b11);
        wr_idx    <= 2'd0;
      end else if (state == ACCESS) begin
        wr_idx <= wr_idx + 2'd1;
      end

      // The counter is cleared outside WAIT_DONE, so it is 0 on entry.
      if (state == WAIT_DONE) cnt <= cnt + CW'(1);
      else                    cnt <= '0;

      // Done is checked before timeout, so a done in the last counted cycle
      // still produces a good result.
      if (state == WAIT_DONE && next_state == RESP) begin
        if (!lat_bad && operation_done) begin
          res_data   <= data_out;
          res_errors <= num_of_errors;
          res_err    <= 1'b0;
        end else begin
          res_data   <= '0;
          res_errors <= 2'd0;
          res_err    <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    next_state = state;
    PSEL       = 1'b0;
    PENABLE    = 1'b0;
    PWRITE     = 1'b0;
    PADDR      = '0;
    PWDATA     = '0;
    res_valid  = 1'b0;

    case (state)
      IDLE: begin
        if (accept) next_state = (job_ctrl == 2'b11 || job_width == 2'b11) ? WAIT_DONE : SETUP;
      end
      SETUP:  next_state = ACCESS;
      ACCESS: next_state = (wr_idx == 2'd3) ? WAIT_DONE : SETUP;
      WAIT_DONE: begin
        if (lat_bad || operation_done || timeout) next_state = RESP;
      end
      RESP: begin
        res_valid  = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase

    // Address and data depend only on the write index, so they are stable
    // across the SETUP/ACCESS pair.
    if (state == SETUP || state == ACCESS) begin
      PSEL    = 1'b1;
      PENABLE = (state == ACCESS);
      PWRITE  = 1'b1;
      case (wr_idx)
        2'd0: begin PADDR = AMBA_ADDR_WIDTH'(8'h04); PWDATA = AMBA_WORD'(lat_data);  end
        2'd1: begin PADDR = AMBA_ADDR_WIDTH'(8'h08); PWDATA = AMBA_WORD'(lat_width); end
        2'd2: begin PADDR = AMBA_ADDR_WIDTH'(8'h0C); PWDATA = AMBA_WORD'(lat_noise); end
        default: begin PADDR = AMBA_ADDR_WIDTH'(8'h00); PWDATA = AMBA_WORD'(lat_ctrl); end
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_apb_driver.sv
// tb_ecc_apb_driver
//   Directed bench for ecc_apb_driver. Inputs change on the falling edge and
//   outputs are sampled on the falling edge, half a cycle away from the
//   active rising edge. "Cycle T" is the cycle whose rising edge accepts a job.
module tb_ecc_apb_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_valid, job_ready;
  logic [1:0]  job_ctrl, job_width;
  logic [31:0] job_data, job_noise;
  logic [19:0] PADDR;
  logic [31:0] PWDATA, PRDATA;
  logic        PSEL, PENABLE, PWRITE;
  logic        operation_done;
  logic [31:0] data_out;
  logic [1:0]  num_of_errors;
  logic        res_valid;
  logic [31:0] res_data;
  logic [1:0]  res_errors;
  logic        res_err;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  int psel_cnt = 0;
  int rv_cnt   = 0;
  logic prev_access = 1'b0;

  always #5 clk = ~clk;

  ecc_apb_driver #(
    .AMBA_WORD(32), .AMBA_ADDR_WIDTH(20), .DATA_WIDTH(32), .TIMEOUT_CYCLES(1024)
  ) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_ctrl(job_ctrl), .job_width(job_width),
    .job_data(job_data), .job_noise(job_noise),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PRDATA(PRDATA),
    .operation_done(operation_done), .data_out(data_out),
    .num_of_errors(num_of_errors),
    .res_valid(res_valid), .res_data(res_data), .res_errors(res_errors),
    .res_err(res_err), .dbg_state(dbg_state)
  );

  // Activity counters and the "no two ACCESS cycles in a row" rule.
  always @(negedge clk) begin
    if (!rst) begin
      if (PSEL) psel_cnt++;
      if (res_valid) rv_cnt++;
      if (PSEL && PENABLE) begin
        total++;
        if (prev_access) begin
          bad++;
          $display("FAIL access_twice t=%0t got=consecutive ACCESS exp=SETUP between", $time);
        end
      end
      prev_access = PSEL && PENABLE;
    end else begin
      prev_access = 1'b0;
    end
  end

  // Offer a job starting at the current falling edge. Returns at the falling
  // edge of cycle T+1 with job_valid dropped.
  task automatic offer(input logic [1:0] c, input logic [1:0] w,
                       input logic [31:0] d, input logic [31:0] n);
    job_ctrl  = c;
    job_width = w;
    job_data  = d;
    job_noise = n;
    job_valid = 1'b1;
    for (int k = 0; k < 50 && job_ready !== 1'b1; k++) @(negedge clk);
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    job_valid = 1'b0; job_ctrl = 2'd0; job_width = 2'd0;
    job_data = '0; job_noise = '0; PRDATA = '0;
    operation_done = 1'b0; data_out = '0; num_of_errors = 2'd0;
    repeat (3) @(negedge clk);
    total++;
    if ({job_ready, PSEL, PENABLE, PWRITE, PADDR, PWDATA, res_valid, res_data, res_errors, res_err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got ready=%b psel=%b paddr=%h res_valid=%b res_data=%h exp=all zero",
               job_ready, PSEL, PADDR, res_valid, res_data);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (job_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready_rise got=%b exp=1", job_ready);
    end
  endtask

  task automatic test_encode();
    logic [19:0] ea [4];
    logic [31:0] ed [4];
    logic [54:0] exp_v, got_v;
    ea[0] = 20'h04; ea[1] = 20'h08; ea[2] = 20'h0C; ea[3] = 20'h00;
    ed[0] = 32'hA5; ed[1] = 32'h1;  ed[2] = 32'h0;  ed[3] = 32'h0;
    offer(2'b00, 2'b01, 32'h0000_00A5, 32'h0);
    for (int i = 0; i < 8; i++) begin
      exp_v = {1'b1, 1'(i % 2), 1'b1, ea[i/2], ed[i/2]};
      got_v = {PSEL, PENABLE, PWRITE, PADDR, PWDATA};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL encode_write%0d got=%h exp=%h", i, got_v, exp_v);
      end
      if (i < 7) @(negedge clk);
    end
    @(negedge clk); // T+9
    total++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== '0 || dbg_state !== 3'd3) begin
      bad++;
      $display("FAIL encode_wait_entry got psel=%b paddr=%h state=%0d exp=idle bus, state 3", PSEL, PADDR, dbg_state);
    end
    repeat (2) @(negedge clk); // T+11
    total++;
    if (res_valid !== 1'b0) begin
      bad++;
      $display("FAIL encode_early_res got=%b exp=0", res_valid);
    end
    @(negedge clk); // T+12
    operation_done = 1'b1; data_out = 32'h1234; num_of_errors = 2'd0;
    @(negedge clk); // T+13
    operation_done = 1'b0; data_out = 32'hFFFF_FFFF;
    total++;
    if ({res_valid, res_data, res_errors, res_err, job_ready} !== {1'b1, 32'h1234, 2'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL encode_result got valid=%b data=%h err=%b ready=%b exp=1 00001234 0 0",
               res_valid, res_data, res_err, job_ready);
    end
    @(negedge clk); // T+14
    total++;
    if ({res_valid, job_ready, res_data} !== {1'b0, 1'b1, 32'h1234}) begin
      bad++;
      $display("FAIL encode_after got valid=%b ready=%b data=%h exp=0 1 00001234", res_valid, job_ready, res_data);
    end
  endtask

  task automatic test_full_channel();
    logic [19:0] ea [4];
    logic [31:0] ed [4];
    logic [54:0] exp_v, got_v;
    ea[0] = 20'h04; ea[1] = 20'h08; ea[2] = 20'h0C; ea[3] = 20'h00;
    ed[0] = 32'hDEAD_BEEF; ed[1] = 32'h2; ed[2] = 32'h1; ed[3] = 32'h2;
    offer(2'b10, 2'b10, 32'hDEAD_BEEF, 32'h0000_0001);
    for (int i = 0; i < 8; i++) begin
      exp_v = {1'b1, 1'(i % 2), 1'b1, ea[i/2], ed[i/2]};
      got_v = {PSEL, PENABLE, PWRITE, PADDR, PWDATA};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL full_write%0d got=%h exp=%h", i, got_v, exp_v);
      end
      if (i < 7) @(negedge clk);
    end
    @(negedge clk); // T+9, done in first WAIT_DONE cycle
    operation_done = 1'b1; data_out = 32'h0000_CAFE; num_of_errors = 2'b01;
    @(negedge clk); // T+10
    operation_done = 1'b0;
    total++;
    if ({res_valid, res_data, res_errors, res_err} !== {1'b1, 32'hCAFE, 2'b01, 1'b0}) begin
      bad++;
      $display("FAIL full_result got valid=%b data=%h errors=%b err=%b exp=1 0000cafe 01 0",
               res_valid, res_data, res_errors, res_err);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    offer(2'b00, 2'b00, 32'h5A, 32'h0);
    repeat (8) @(negedge clk); // T+9
    for (int k = 0; k < 1024; k++) begin
      if (res_valid) early++;
      @(negedge clk);
    end // T+1033
    total++;
    if (early !== 0) begin
      bad++;
      $display("FAIL timeout_early got=%0d exp=0", early);
    end
    total++;
    if ({res_valid, res_err, res_data, res_errors} !== {1'b1, 1'b1, 32'h0, 2'd0}) begin
      bad++;
      $display("FAIL timeout_result got valid=%b err=%b data=%h errors=%b exp=1 1 0 0",
               res_valid, res_err, res_data, res_errors);
    end
    @(negedge clk);
    total++;
    if ({job_ready, res_valid} !== 2'b10) begin
      bad++;
      $display("FAIL timeout_ready got ready=%b valid=%b exp=1 0", job_ready, res_valid);
    end
  endtask

  task automatic test_done_last_cycle();
    offer(2'b01, 2'b00, 32'h3C, 32'h0);
    repeat (8) @(negedge clk);    // T+9
    repeat (1023) @(negedge clk); // T+1032, last counted cycle
    operation_done = 1'b1; data_out = 32'h77; num_of_errors = 2'd2;
    @(negedge clk);
    operation_done = 1'b0;
    total++;
    if ({res_valid, res_err, res_data, res_errors} !== {1'b1, 1'b0, 32'h77, 2'd2}) begin
      bad++;
      $display("FAIL done_last_cycle got valid=%b err=%b data=%h errors=%b exp=1 0 00000077 2",
               res_valid, res_err, res_data, res_errors);
    end
    @(negedge clk);
  endtask

  task automatic test_reserved();
    int p0;
    logic [1:0] rc [2];
    logic [1:0] rw [2];
    rc[0] = 2'b00; rw[0] = 2'b11;
    rc[1] = 2'b11; rw[1] = 2'b00;
    p0 = psel_cnt;
    // A done pulse and live data must not leak into the error result.
    operation_done = 1'b1; data_out = 32'hFFFF; num_of_errors = 2'd3;
    for (int j = 0; j < 2; j++) begin
      offer(rc[j], rw[j], 32'h1, 32'h2); // T+1
      total++;
      if ({res_valid, PSEL} !== 2'b00) begin
        bad++;
        $display("FAIL reserved%0d_t1 got valid=%b psel=%b exp=0 0", j, res_valid, PSEL);
      end
      @(negedge clk); // T+2
      total++;
      if ({res_valid, res_err, res_data, res_errors} !== {1'b1, 1'b1, 32'h0, 2'd0}) begin
        bad++;
        $display("FAIL reserved%0d_result got valid=%b err=%b data=%h errors=%b exp=1 1 0 0",
                 j, res_valid, res_err, res_data, res_errors);
      end
      @(negedge clk);
    end
    operation_done = 1'b0;
    total++;
    if (psel_cnt - p0 !== 0) begin
      bad++;
      $display("FAIL reserved_no_apb got=%0d psel cycles exp=0", psel_cnt - p0);
    end
  endtask

  task automatic test_reset_mid();
    int p0, r0;
    offer(2'b00, 2'b10, 32'h33, 32'h44); // T+1
    repeat (5) @(negedge clk);           // T+6, NOISE ACCESS
    total++;
    if ({PSEL, PENABLE, PADDR, PWDATA} !== {1'b1, 1'b1, 20'h0C, 32'h44}) begin
      bad++;
      $display("FAIL rstmid_noise_access got psel=%b pen=%b paddr=%h pwdata=%h exp=1 1 0000c 00000044",
               PSEL, PENABLE, PADDR, PWDATA);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({job_ready, PSEL, PENABLE, PWRITE, PADDR, PWDATA, res_valid, res_data, res_errors, res_err} !== '0) begin
      bad++;
      $display("FAIL rstmid_async_zero got ready=%b psel=%b paddr=%h res_data=%h exp=all zero",
               job_ready, PSEL, PADDR, res_data);
    end
    @(negedge clk);
    rst = 1'b0;
    p0 = psel_cnt; r0 = rv_cnt;
    repeat (10) @(negedge clk);
    total++;
    if ((psel_cnt - p0) !== 0 || (rv_cnt - r0) !== 0 || job_ready !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_abort got psel=%0d rv=%0d ready=%b exp=0 0 1", psel_cnt - p0, rv_cnt - r0, job_ready);
    end
    offer(2'b01, 2'b00, 32'h99, 32'h5); // T+1
    repeat (8) @(negedge clk);          // T+9
    operation_done = 1'b1; data_out = 32'hBEEF; num_of_errors = 2'd3;
    @(negedge clk);
    operation_done = 1'b0;
    total++;
    if ({res_valid, res_err, res_data, res_errors} !== {1'b1, 1'b0, 32'hBEEF, 2'd3}) begin
      bad++;
      $display("FAIL rstmid_new_job got valid=%b err=%b data=%h errors=%b exp=1 0 0000beef 3",
               res_valid, res_err, res_data, res_errors);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic exp_psel, exp_rdy, exp_rv;
    total++;
    if (job_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_start_ready got=%b exp=1", job_ready);
    end
    job_ctrl = 2'b00; job_width = 2'b00; job_data = 32'h1; job_noise = 32'h0;
    job_valid = 1'b1;
    operation_done = 1'b1; data_out = 32'h1111; num_of_errors = 2'd1;
    for (int t = 0; t <= 22; t++) begin
      if (t == 14) data_out = 32'h2222;
      if (t == 21) job_valid = 1'b0;
      exp_psel = (t >= 1 && t <= 8) || (t >= 12 && t <= 19);
      exp_rdy  = (t == 0) || (t == 11) || (t == 22);
      exp_rv   = (t == 10) || (t == 21);
      total++;
      if ({PSEL, job_ready, res_valid} !== {exp_psel, exp_rdy, exp_rv}) begin
        bad++;
        $display("FAIL b2b_t%0d got psel=%b ready=%b valid=%b exp=%b %b %b",
                 t, PSEL, job_ready, res_valid, exp_psel, exp_rdy, exp_rv);
      end
      if (t == 10 || t == 21) begin
        total++;
        if (res_data !== ((t == 10) ? 32'h1111 : 32'h2222)) begin
          bad++;
          $display("FAIL b2b_data_t%0d got=%h exp=%h", t, res_data, (t == 10) ? 32'h1111 : 32'h2222);
        end
      end
      @(negedge clk);
    end
    operation_done = 1'b0;
    job_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_encode();
    test_full_channel();
    test_reserved();
    test_timeout();
    test_done_last_cycle();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
